// File: rtl/glitch_mon_pkg.sv
// Shared types and defaults for the glitch monitor.
// Optional build macro: GLITCH_MON_SYNC_EN (input synchronizers).
package glitch_mon_pkg;

  localparam int unsigned DEF_DELAY_W = 64;
  localparam int unsigned DEF_WIDTH_W = 32;
  localparam logic [63:0] DEF_TIMEOUT = 64'd1_000_000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DELAY  = 3'd1,
    ST_WIDTH  = 3'd2,
    ST_REPORT = 3'd3,
    ST_REARM  = 3'd4
  } state_t;

endpackage

// File: rtl/glitch_monitor_if.sv
// Measurement result handshake between monitor and readout logic.
// Master drives the result, slave drives meas_ready.
interface glitch_monitor_if
  import glitch_mon_pkg::*;
#(
  parameter int unsigned DELAY_W = DEF_DELAY_W,
  parameter int unsigned WIDTH_W = DEF_WIDTH_W
) ();

  logic               meas_valid;
  logic               meas_ready;
  logic [DELAY_W-1:0] meas_delay;
  logic [WIDTH_W-1:0] meas_width;
  logic               meas_timeout;

  modport master (
    output meas_valid,
    output meas_delay,
    output meas_width,
    output meas_timeout,
    input  meas_ready
  );

  modport slave (
    input  meas_valid,
    input  meas_delay,
    input  meas_width,
    input  meas_timeout,
    output meas_ready
  );

endinterface

// File: rtl/glitch_sync.sv
// Two-flop synchronizer, asynchronously reset to 0.
// Used on trigger/glitch lines when GLITCH_MON_SYNC_EN is defined.
module glitch_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // shift the raw input through two flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/glitch_monitor.sv
// Measures trigger-to-glitch delay and glitch width in clk cycles.
// Define GLITCH_MON_SYNC_EN to synchronize both input lines.
module glitch_monitor
  import glitch_mon_pkg::*;
#(
  parameter int unsigned        DELAY_W        = DEF_DELAY_W,
  parameter int unsigned        WIDTH_W        = DEF_WIDTH_W,
  parameter logic [DELAY_W-1:0] TIMEOUT_CYCLES = DELAY_W'(DEF_TIMEOUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              glitch_in,
  output logic              busy,
  glitch_monitor_if.master  meas
);

  logic w_trig_in;
  logic w_glt_in;

`ifdef GLITCH_MON_SYNC_EN
  glitch_sync u_sync_trig (
    .clk (clk),
    .rst (rst),
    .i_d (trigger),
    .o_q (w_trig_in)
  );

  glitch_sync u_sync_glt (
    .clk (clk),
    .rst (rst),
    .i_d (glitch_in),
    .o_q (w_glt_in)
  );
`else
  assign w_trig_in = trigger;
  assign w_glt_in  = glitch_in;
`endif

  logic r_trig_s;
  logic r_trig_d;
  logic r_glt_s;
  logic r_glt_d;

  // sample lines and keep one-cycle history for edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig_s <= 1'b0;
      r_trig_d <= 1'b0;
      r_glt_s  <= 1'b0;
      r_glt_d  <= 1'b0;
    end else begin
      r_trig_s <= w_trig_in;
      r_trig_d <= r_trig_s;
      r_glt_s  <= w_glt_in;
      r_glt_d  <= r_glt_s;
    end
  end

  logic w_trig_rise;
  logic w_glt_rise;

  assign w_trig_rise = r_trig_s & ~r_trig_d;
  assign w_glt_rise  = r_glt_s & ~r_glt_d;

  state_t             r_state;
  logic [DELAY_W-1:0] r_dcnt;
  logic [WIDTH_W-1:0] r_wcnt;
  logic [WIDTH_W-1:0] w_wnext;
  logic               r_valid;
  logic [DELAY_W-1:0] r_delay;
  logic [WIDTH_W-1:0] r_width;
  logic               r_timeout;
  logic               r_busy;

  // width count sticks at all-ones instead of wrapping
  assign w_wnext = (&r_wcnt) ? r_wcnt : r_wcnt + 1'b1;

  // measurement FSM with registered results and busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_dcnt    <= '0;
      r_wcnt    <= '0;
      r_valid   <= 1'b0;
      r_delay   <= '0;
      r_width   <= '0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_dcnt <= '0;
          r_wcnt <= '0;
          if (w_trig_rise) begin
            r_timeout <= 1'b0;
            r_busy    <= 1'b1;
            if (w_glt_rise) begin
              r_delay <= '0;
              r_wcnt  <= WIDTH_W'(1);
              r_state <= ST_WIDTH;
            end else begin
              r_dcnt  <= DELAY_W'(1);
              r_state <= ST_DELAY;
            end
          end
        end
        ST_DELAY: begin
          if (w_glt_rise) begin
            r_delay <= r_dcnt;
            r_wcnt  <= WIDTH_W'(1);
            r_state <= ST_WIDTH;
          end else if (r_dcnt == TIMEOUT_CYCLES) begin
            r_delay   <= TIMEOUT_CYCLES;
            r_width   <= '0;
            r_timeout <= 1'b1;
            r_valid   <= 1'b1;
            r_state   <= ST_REPORT;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        ST_WIDTH: begin
          if (r_glt_s) begin
            r_wcnt <= w_wnext;
          end else begin
            r_width <= r_wcnt;
            r_valid <= 1'b1;
            r_state <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (meas.meas_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_REARM;
          end
        end
        ST_REARM: begin
          if (!r_trig_s) begin
            r_dcnt  <= '0;
            r_wcnt  <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign meas.meas_valid   = r_valid;
  assign meas.meas_delay   = r_delay;
  assign meas.meas_width   = r_width;
  assign meas.meas_timeout = r_timeout;
  assign busy              = r_busy;

endmodule
